// File: rtl/mac_master_0.sv
// Bus master for the MAC slave: streams a host-loaded operand buffer under a
// continuous select, then waits (bounded) for the slave acknowledge and captures its result.
module mac_master_0 #(
    parameter int PAIRS   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(PAIRS)-1:0]   wr_addr,
    input  logic [15:0]                wr_data,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout_err,
    output logic [31:0]                result,
    output logic                       sel,
    output logic [31:0]                m_data_out_0,
    input  logic                       ack,
    input  logic [31:0]                m_data_in_0
);

    localparam int AW = $clog2(PAIRS);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [AW:0]   PAIRS_V = (AW+1)'(PAIRS);
    localparam logic [AW:0]   IDX_ONE = (AW+1)'(1'b1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [15:0]   buf_r [PAIRS];
    logic [AW:0]   idx_r, idx_s;
    logic [CW-1:0] wcnt_r, wcnt_s;
    logic          sel_s, done_s, terr_s, buf_wr_s;
    logic [31:0]   data_s, result_s;
    logic [15:0]   buf_rd_s;

    // idx_r holds the index of the next pair to present; reaching PAIRS means all were sent
    assign buf_rd_s = buf_r[idx_r[AW-1:0]];
    assign buf_wr_s = wr_en && (state_r == IDLE) && !start;
    assign busy     = (state_r != IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = SEND;
                else       state_s = IDLE;
            end
            SEND: begin
                if (idx_r == PAIRS_V) state_s = WAIT;
                else                  state_s = SEND;
            end
            WAIT: begin
                if (ack)                    state_s = IDLE;
                else if (wcnt_r == TO_LAST) state_s = IDLE;
                else                        state_s = WAIT;
            end
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs and counters
    always_comb begin
        sel_s    = 1'b0;
        data_s   = 32'h0000_0000;
        done_s   = 1'b0;
        terr_s   = 1'b0;
        result_s = result;
        idx_s    = idx_r;
        wcnt_s   = wcnt_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    sel_s  = 1'b1;
                    data_s = {16'h0000, buf_r[0]};
                    idx_s  = IDX_ONE;
                end else begin
                    idx_s  = '0;
                    wcnt_s = '0;
                end
            end
            SEND: begin
                sel_s = 1'b1;
                if (idx_r == PAIRS_V) begin
                    data_s = 32'h0000_0000;
                    wcnt_s = '0;
                end else begin
                    data_s = {16'h0000, buf_rd_s};
                    idx_s  = idx_r + IDX_ONE;
                end
            end
            WAIT: begin
                // ack on the final permitted cycle still counts as success
                if (ack) begin
                    result_s = m_data_in_0;
                    done_s   = 1'b1;
                end else if (wcnt_r == TO_LAST) begin
                    terr_s = 1'b1;
                end else begin
                    sel_s  = 1'b1;
                    wcnt_s = wcnt_r + CNT_ONE;
                end
            end
            default: begin
                sel_s = 1'b0;
            end
        endcase
    end

    // Output and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel          <= 1'b0;
            m_data_out_0 <= 32'h0000_0000;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
            result       <= 32'h0000_0000;
            idx_r        <= '0;
            wcnt_r       <= '0;
        end else begin
            sel          <= sel_s;
            m_data_out_0 <= data_s;
            done         <= done_s;
            timeout_err  <= terr_s;
            result       <= result_s;
            idx_r        <= idx_s;
            wcnt_r       <= wcnt_s;
        end
    end

    // Operand buffer, writable only while idle and not starting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PAIRS; i++) buf_r[i] <= 16'h0000;
        end else if (buf_wr_s) begin
            buf_r[wr_addr] <= wr_data;
        end
    end

endmodule
